// File: rtl/simple_dual_pkg.sv
// Shared constants, helper function and read-pipeline record for the dual-port RAM arbiter.
// SIMPLE_DUAL_ARB_FWD_EN widens the pipeline record with write-forwarding fields.
package simple_dual_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 10;
   localparam int BE_W     = 4;
   localparam int ID_W_MAX = 3;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 16; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Sized for the largest supported requester count so the record stays fixed-width.
   typedef struct packed {
      logic                valid;
      logic [ID_W_MAX-1:0] id;
`ifdef SIMPLE_DUAL_ARB_FWD_EN
      logic                fwd;
      logic [BE_W-1:0]     be;
      logic [DATA_W-1:0]   data;
`endif
   } rd_stage_t;

endpackage

// File: rtl/simple_dual_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at ptr and wraps.
module rr_arbiter
   import simple_dual_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt_idx;
   logic          found;

   // The second pass only runs when nothing at or above ptr requested, so it picks the wrapped winner.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (PW'(i) >= ptr)) begin
            gnt[i]  = 1'b1;
            gnt_idx = PW'(i);
            found   = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            gnt[i]  = 1'b1;
            gnt_idx = PW'(i);
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

endmodule

// File: rtl/simple_dual_arbiter.sv
// Shares one simple dual-port RAM among NUM_REQ requesters with separate write/read arbitration.
// Define SIMPLE_DUAL_ARB_FWD_EN to forward same-cycle, same-address write data into the read.
module simple_dual_arbiter
   import simple_dual_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = DATA_W,
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int WEA_WIDTH  = BE_W,
   parameter int ID_WIDTH   = clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              wr_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   wr_addr,
   input  logic [NUM_REQ*WIDTH-1:0]        wr_data,
   input  logic [NUM_REQ*WEA_WIDTH-1:0]    wr_be,
   output logic [NUM_REQ-1:0]              wr_gnt,
   input  logic [NUM_REQ-1:0]              rd_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_REQ-1:0]              rd_gnt,
   output logic                            rd_valid,
   output logic [ID_WIDTH-1:0]             rd_id,
   output logic [WIDTH-1:0]                rd_data,
   output logic                            ram_ena,
   output logic [WEA_WIDTH-1:0]            ram_wea,
   output logic [ADDR_WIDTH-1:0]           ram_addra,
   output logic [WIDTH-1:0]                ram_dina,
   output logic                            ram_enb,
   output logic [ADDR_WIDTH-1:0]           ram_addrb,
   input  logic [WIDTH-1:0]                ram_doutb
);

   function automatic logic [ID_WIDTH-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
      onehot_to_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) begin
            onehot_to_idx = ID_WIDTH'(i);
         end
      end
   endfunction

   logic [ID_WIDTH-1:0] wr_g;
   logic [ID_WIDTH-1:0] rd_g;
   rd_stage_t           s1;
   rd_stage_t           s2;

   rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
      .clk (clk),
      .rst (rst),
      .req (wr_req),
      .gnt (wr_gnt)
   );

   rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
      .clk (clk),
      .rst (rst),
      .req (rd_req),
      .gnt (rd_gnt)
   );

   assign wr_g = onehot_to_idx(wr_gnt);
   assign rd_g = onehot_to_idx(rd_gnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_ena   <= 1'b0;
         ram_wea   <= '0;
         ram_addra <= '0;
         ram_dina  <= '0;
      end else begin
         ram_ena <= |wr_gnt;
         if (|wr_gnt) begin
            ram_wea   <= wr_be[wr_g*WEA_WIDTH +: WEA_WIDTH];
            ram_addra <= wr_addr[wr_g*ADDR_WIDTH +: ADDR_WIDTH];
            ram_dina  <= wr_data[wr_g*WIDTH +: WIDTH];
         end else begin
            ram_wea <= '0;
         end
      end
   end

   // Stage 1 lines up with the RAM read access; stage 2 lines up with ram_doutb.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_enb   <= 1'b0;
         ram_addrb <= '0;
         s1        <= '0;
         s2        <= '0;
      end else begin
         ram_enb  <= |rd_gnt;
         if (|rd_gnt) begin
            ram_addrb <= rd_addr[rd_g*ADDR_WIDTH +: ADDR_WIDTH];
         end
         s1.valid <= |rd_gnt;
         s1.id    <= ID_W_MAX'(rd_g);
`ifdef SIMPLE_DUAL_ARB_FWD_EN
         s1.fwd   <= (|wr_gnt) && (|rd_gnt) &&
                     (wr_addr[wr_g*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[rd_g*ADDR_WIDTH +: ADDR_WIDTH]);
         s1.be    <= BE_W'(wr_be[wr_g*WEA_WIDTH +: WEA_WIDTH]);
         s1.data  <= DATA_W'(wr_data[wr_g*WIDTH +: WIDTH]);
`endif
         s2       <= s1;
      end
   end

   assign rd_valid = s2.valid;
   assign rd_id    = ID_WIDTH'(s2.id);

`ifdef SIMPLE_DUAL_ARB_FWD_EN
   always_comb begin
      rd_data = ram_doutb;
      if (s2.fwd) begin
         for (int k = 0; k < WEA_WIDTH; k++) begin
            if (s2.be[k]) begin
               rd_data[8*k +: 8] = s2.data[8*k +: 8];
            end
         end
      end
   end
`else
   assign rd_data = ram_doutb;
`endif

endmodule

// File: tb/tb_simple_dual_arbiter.sv
// Self-checking bench for simple_dual_arbiter: arbitration vector table, scoreboarded read
// responses against a behavioural RAM, and hand-written ordering/reset sequences.
module tb_simple_dual_arbiter;

   localparam int NR = 4;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NR-1:0]    wr_req = '0;
   logic [NR*AW-1:0] wr_addr = '0;
   logic [NR*DW-1:0] wr_data = '0;
   logic [NR*BW-1:0] wr_be = '0;
   logic [NR-1:0]    wr_gnt;
   logic [NR-1:0]    rd_req = '0;
   logic [NR*AW-1:0] rd_addr = '0;
   logic [NR-1:0]    rd_gnt;
   logic             rd_valid;
   logic [1:0]       rd_id;
   logic [DW-1:0]    rd_data;
   logic             ram_ena;
   logic [BW-1:0]    ram_wea;
   logic [AW-1:0]    ram_addra;
   logic [DW-1:0]    ram_dina;
   logic             ram_enb;
   logic [AW-1:0]    ram_addrb;
   logic [DW-1:0]    ram_doutb = '0;

   simple_dual_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .wr_gnt    (wr_gnt),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_gnt    (rd_gnt),
      .rd_valid  (rd_valid),
      .rd_id     (rd_id),
      .rd_data   (rd_data),
      .ram_ena   (ram_ena),
      .ram_wea   (ram_wea),
      .ram_addra (ram_addra),
      .ram_dina  (ram_dina),
      .ram_enb   (ram_enb),
      .ram_addrb (ram_addrb),
      .ram_doutb (ram_doutb)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: byte-write port A, registered read port B, read-old-data on collision.
   logic [DW-1:0] mem [0:1023];
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
   end
   always @(posedge clk) begin
      if (ram_ena) begin
         for (int k = 0; k < BW; k++) begin
            if (ram_wea[k]) mem[ram_addra][8*k +: 8] <= ram_dina[8*k +: 8];
         end
      end
      if (ram_enb) ram_doutb <= mem[ram_addrb];
   end

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      logic [3:0] wr;
      logic [3:0] rd;
      logic [3:0] wg;
      logic [3:0] rg;
   } vec_t;

   rsp_t sb[$];
   rsp_t mon_e;
   vec_t tbl[13];
   int   checks = 0;
   int   fails  = 0;

   function automatic logic [1:0] ohIdx(input logic [3:0] oh);
      ohIdx = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) ohIdx = 2'(i);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] wr, input logic [3:0] rd);
      wr_req = wr;
      rd_req = rd;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      applyStimulus(4'h0, 4'h0);
      repeat (n) nextCycle();
   endtask

   task automatic setWr(input int i, input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
      wr_addr[i*AW +: AW] = a;
      wr_data[i*DW +: DW] = d;
      wr_be[i*BW +: BW]   = b;
   endtask

   task automatic setRd(input int i, input logic [9:0] a);
      rd_addr[i*AW +: AW] = a;
   endtask

   task automatic doWrite(input int i, input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
      setWr(i, a, d, b);
      applyStimulus(4'(1 << i), 4'h0);
      @(negedge clk);
      checkOutput("wr_gnt_single", 32'(wr_gnt), 32'(1 << i));
      nextCycle();
      applyStimulus(4'h0, 4'h0);
   endtask

   task automatic doRead(input int i, input logic [9:0] a, input logic [31:0] d);
      setRd(i, a);
      applyStimulus(4'h0, 4'(1 << i));
      sb.push_back('{id: 2'(i), data: d});
      @(negedge clk);
      checkOutput("rd_gnt_single", 32'(rd_gnt), 32'(1 << i));
      nextCycle();
      applyStimulus(4'h0, 4'h0);
   endtask

   // Every read response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_rsp: got rd_valid=1 id=%0d, expected no response at %0t", rd_id, $time);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("rsp_id", 32'(rd_id), 32'(mon_e.id));
            checkOutput("rsp_data", rd_data, mon_e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected $finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] exp_same;

      tbl[0]  = '{4'hF, 4'h0, 4'h1, 4'h0};
      tbl[1]  = '{4'hF, 4'hA, 4'h2, 4'h2};
      tbl[2]  = '{4'hF, 4'hA, 4'h4, 4'h8};
      tbl[3]  = '{4'hF, 4'h1, 4'h8, 4'h1};
      tbl[4]  = '{4'hF, 4'h0, 4'h1, 4'h0};
      tbl[5]  = '{4'hF, 4'h0, 4'h2, 4'h0};
      tbl[6]  = '{4'hF, 4'h0, 4'h4, 4'h0};
      tbl[7]  = '{4'hF, 4'h0, 4'h8, 4'h0};
      tbl[8]  = '{4'h0, 4'h0, 4'h0, 4'h0};
      tbl[9]  = '{4'h6, 4'h9, 4'h2, 4'h8};
      tbl[10] = '{4'h1, 4'h9, 4'h1, 4'h1};
      tbl[11] = '{4'h8, 4'h4, 4'h8, 4'h4};
      tbl[12] = '{4'h3, 4'h3, 4'h1, 4'h1};

      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_ram_ena", 32'(ram_ena), 32'd0);
      checkOutput("rst_ram_wea", 32'(ram_wea), 32'd0);
      checkOutput("rst_ram_addra", 32'(ram_addra), 32'd0);
      checkOutput("rst_ram_dina", ram_dina, 32'd0);
      checkOutput("rst_ram_enb", 32'(ram_enb), 32'd0);
      checkOutput("rst_ram_addrb", 32'(ram_addrb), 32'd0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_rd_id", 32'(rd_id), 32'd0);
      nextCycle();
      rst = 1'b0;

      // Arbitration table: zero byte enables keep the RAM untouched, reads hit unwritten words.
      for (int i = 0; i < NR; i++) begin
         setWr(i, 10'(32'h100 + i), 32'hFFFF_FFFF, 4'h0);
         setRd(i, 10'(32'h200 + i));
      end
      for (int v = 0; v < 13; v++) begin
         applyStimulus(tbl[v].wr, tbl[v].rd);
         if (tbl[v].rg != 4'h0) sb.push_back('{id: ohIdx(tbl[v].rg), data: 32'h0});
         @(negedge clk);
         checkOutput($sformatf("tbl%0d_wr_gnt", v), 32'(wr_gnt), 32'(tbl[v].wg));
         checkOutput($sformatf("tbl%0d_rd_gnt", v), 32'(rd_gnt), 32'(tbl[v].rg));
         nextCycle();
      end
      idle(4);

      // Basic write then read with port-level timing checks.
      doWrite(0, 10'h005, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      checkOutput("a_ram_ena", 32'(ram_ena), 32'd1);
      checkOutput("a_ram_wea", 32'(ram_wea), 32'hF);
      checkOutput("a_ram_addra", 32'(ram_addra), 32'h005);
      checkOutput("a_ram_dina", ram_dina, 32'hDEAD_BEEF);
      nextCycle();
      doRead(0, 10'h005, 32'hDEAD_BEEF);
      @(negedge clk);
      checkOutput("a_ram_enb", 32'(ram_enb), 32'd1);
      checkOutput("a_ram_addrb", 32'(ram_addrb), 32'h005);
      checkOutput("a_ram_ena_idle", 32'(ram_ena), 32'd0);
      checkOutput("a_rd_valid_early", 32'(rd_valid), 32'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("a_rd_valid_lat2", 32'(rd_valid), 32'd1);
      nextCycle();
      idle(2);

      // Partial byte-enable write over a preloaded word.
      doWrite(2, 10'h010, 32'h1122_3344, 4'hF);
      doWrite(2, 10'h010, 32'hAABB_CCDD, 4'b0101);
      doRead(0, 10'h010, 32'h11BB_33DD);
      idle(3);

      // Back-to-back reads by requesters 1..3; read pointer sits at 1 here.
      doWrite(3, 10'h001, 32'h0101_0101, 4'hF);
      doWrite(3, 10'h002, 32'h0202_0202, 4'hF);
      doWrite(3, 10'h003, 32'h0303_0303, 4'hF);
      setRd(1, 10'h001);
      setRd(2, 10'h002);
      setRd(3, 10'h003);
      sb.push_back('{id: 2'd1, data: 32'h0101_0101});
      sb.push_back('{id: 2'd2, data: 32'h0202_0202});
      sb.push_back('{id: 2'd3, data: 32'h0303_0303});
      applyStimulus(4'h0, 4'hE);
      @(negedge clk);
      checkOutput("d_rd_gnt0", 32'(rd_gnt), 32'h2);
      nextCycle();
      applyStimulus(4'h0, 4'hC);
      @(negedge clk);
      checkOutput("d_rd_gnt1", 32'(rd_gnt), 32'h4);
      nextCycle();
      applyStimulus(4'h0, 4'h8);
      @(negedge clk);
      checkOutput("d_rd_gnt2", 32'(rd_gnt), 32'h8);
      checkOutput("d_valid0", 32'(rd_valid), 32'd1);
      nextCycle();
      applyStimulus(4'h0, 4'h0);
      @(negedge clk);
      checkOutput("d_valid1", 32'(rd_valid), 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput("d_valid2", 32'(rd_valid), 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput("d_valid_end", 32'(rd_valid), 32'd0);
      nextCycle();
      idle(2);

      // Same-cycle write and read of one address, then write followed by read next cycle.
`ifdef SIMPLE_DUAL_ARB_FWD_EN
      exp_same = 32'hCAFE_F00D;
`else
      exp_same = 32'h0000_0000;
`endif
      setWr(1, 10'h3FF, 32'hCAFE_F00D, 4'hF);
      setRd(1, 10'h3FF);
      applyStimulus(4'h2, 4'h2);
      sb.push_back('{id: 2'd1, data: exp_same});
      @(negedge clk);
      checkOutput("c_wr_gnt", 32'(wr_gnt), 32'h2);
      checkOutput("c_rd_gnt", 32'(rd_gnt), 32'h2);
      nextCycle();
      idle(3);
      doWrite(0, 10'h3FE, 32'h1234_5678, 4'hF);
      doRead(0, 10'h3FE, 32'h1234_5678);
      idle(3);

      // Reset in the cycle after grants: in-flight read and registered write are both dropped.
      setWr(0, 10'h0AA, 32'h5555_5555, 4'hF);
      setRd(0, 10'h200);
      applyStimulus(4'h1, 4'h1);
      @(negedge clk);
      checkOutput("e_wr_gnt", 32'(wr_gnt), 32'h1);
      checkOutput("e_rd_gnt", 32'(rd_gnt), 32'h1);
      nextCycle();
      applyStimulus(4'h0, 4'h0);
      #1 rst = 1'b1;
      #1;
      checkOutput("e_ram_enb_async", 32'(ram_enb), 32'd0);
      checkOutput("e_ram_ena_async", 32'(ram_ena), 32'd0);
      checkOutput("e_rd_valid_async", 32'(rd_valid), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      wr_be = '0;
      setRd(0, 10'h0AA);
      applyStimulus(4'hF, 4'hF);
      sb.push_back('{id: 2'd0, data: 32'h0});
      @(negedge clk);
      checkOutput("e_wr_ptr_reset", 32'(wr_gnt), 32'h1);
      checkOutput("e_rd_ptr_reset", 32'(rd_gnt), 32'h1);
      nextCycle();
      idle(5);

      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
